char_row_fetch: RTL and testbench



---
 rtl/homelab_video_pkg.sv | 12 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/char_row_fetch.sv | 155 +++++++++++++++
 tb/tb_char_row_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/homelab_video_pkg.sv
// Shared types and default geometry for the text-mode video fetch path.
package homelab_video_pkg;

  localparam int unsigned COLS    = 64;
  localparam int unsigned GLYPH_H = 8;
  localparam int unsigned CROM_AW = 11;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

  typedef logic [7:0] glyph_byte_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head; count includes the head entry.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] head_q, head_d;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign rd_next = rd_ptr_q + PtrW'(1);

  always_comb begin
    count_d = count_q + CntW'(push_i) - CntW'(do_pop);
    head_d  = head_q;
    // Head register mirrors mem[rd_ptr]; a push into an empty slot bypasses memory.
    if (do_pop) begin
      if (count_q > CntW'(1)) head_d = mem_q[rd_next];
      else if (push_i)        head_d = wdata_i;
    end else if ((count_q == '0) && push_i) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop) rd_ptr_q <= rd_next;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/char_row_fetch.sv
// Fetches one text scanline (codes from video RAM, glyphs from char ROM) into a pixel stream.
// Optional INVERSE_VIDEO_EN: code bit 7 selects a bit-inverted glyph byte.
module char_row_fetch
  import homelab_video_pkg::*;
#(
  parameter int unsigned VRAM_AW    = 11,
  parameter int unsigned VRAM_BASE  = 0,
  parameter int unsigned COLS       = homelab_video_pkg::COLS,
  parameter int unsigned GLYPH_H    = homelab_video_pkg::GLYPH_H,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               line_start,
  input  logic [7:0]         line_num,
  output logic               vram_cs,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [7:0]         vram_q,
  output logic [CROM_AW-1:0] crom_addr,
  input  logic [7:0]         crom_q,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [7:0]         pix_data,
  output logic               busy,
  output logic               line_done
);

  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t       state_q, state_d;
  logic [7:0]         char_row_q, char_row_d;
  logic [2:0]         glyph_row_q, glyph_row_d;
  logic [ColW-1:0]    col_q, col_d;
  logic               vram_cs_q, vram_cs_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic               busy_q, busy_d;
  logic               line_done_q, line_done_d;
  logic               s1_q, s2_q;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_pop, credit_ok, pipe_empty;
  glyph_byte_t        push_data;

  function automatic logic [VRAM_AW-1:0] row_addr(input logic [7:0] row,
                                                  input logic [ColW-1:0] col);
    return VRAM_AW'(VRAM_BASE + 32'(row) * COLS + 32'(col));
  endfunction

  assign fifo_pop   = pix_valid && pix_ready;
  assign pipe_empty = !vram_cs_q && !s1_q && !s2_q;
  // Every fetch in flight already owns a FIFO slot, so a push can never overflow.
  assign credit_ok  = (32'(vram_cs_q) + 32'(s1_q) + 32'(s2_q) + 32'(fifo_count))
                      < (FIFO_DEPTH + 32'(fifo_pop));

  always_comb begin
    state_d     = state_q;
    char_row_d  = char_row_q;
    glyph_row_d = glyph_row_q;
    col_d       = col_q;
    vram_cs_d   = 1'b0;
    vram_addr_d = vram_addr_q;
    busy_d      = busy_q;
    line_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (line_start) begin
          char_row_d  = 8'(32'(line_num) / GLYPH_H);
          glyph_row_d = 3'(32'(line_num) % GLYPH_H);
          vram_cs_d   = 1'b1;
          vram_addr_d = row_addr(char_row_d, '0);
          col_d       = ColW'(1);
          busy_d      = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (credit_ok) begin
          vram_cs_d   = 1'b1;
          vram_addr_d = row_addr(char_row_q, col_q);
          col_d       = col_q + ColW'(1);
          if (col_q == ColW'(COLS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty && ((fifo_count == '0) || ((fifo_count == CntW'(1)) && fifo_pop))) begin
          line_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      char_row_q  <= '0;
      glyph_row_q <= '0;
      col_q       <= '0;
      vram_cs_q   <= 1'b0;
      vram_addr_q <= '0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      char_row_q  <= char_row_d;
      glyph_row_q <= glyph_row_d;
      col_q       <= col_d;
      vram_cs_q   <= vram_cs_d;
      vram_addr_q <= vram_addr_d;
      busy_q      <= busy_d;
      line_done_q <= line_done_d;
      s1_q        <= vram_cs_q;
      s2_q        <= s1_q;
    end
  end

`ifdef INVERSE_VIDEO_EN
  logic inv_q;

  always_ff @(posedge clock) begin
    if (!reset_n)  inv_q <= 1'b0;
    else if (s1_q) inv_q <= vram_q[7];
  end

  assign crom_addr = s1_q ? {1'b0, vram_q[6:0], glyph_row_q} : '0;
  assign push_data = crom_q ^ {8{inv_q}};
`else
  assign crom_addr = s1_q ? {vram_q, glyph_row_q} : '0;
  assign push_data = crom_q;
`endif

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (s2_q),
    .wdata_i (push_data),
    .pop_i   (fifo_pop),
    .valid_o (pix_valid),
    .rdata_o (pix_data),
    .count_o (fifo_count)
  );

  assign vram_cs   = vram_cs_q;
  assign vram_addr = vram_addr_q;
  assign busy      = busy_q;
  assign line_done = line_done_q;

endmodule

// File: tb/tb_char_row_fetch.sv
// Directed bench for char_row_fetch with VRAM/ROM models; VRAM_BASE = 0x7C0 exercises wrap.
module tb_char_row_fetch;

  logic        clock = 1'b0;
  logic        reset_n, line_start, pix_ready;
  logic [7:0]  line_num;
  logic        vram_cs, pix_valid, busy, line_done;
  logic [10:0] vram_addr, crom_addr;
  logic [7:0]  vram_q, crom_q, pix_data;

  logic [7:0]  vmem [2048];
  logic [7:0]  crom [2048];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, first_v = -1, max_cnt = 0, stab_err = 0;
  int s0 = 0, d0 = 0;
  logic [7:0]  got [$];
  logic [10:0] addrs [$];
  logic        prev_valid = 1'b0, prev_pop = 1'b0, prev_rst_n = 1'b0;
  logic [7:0]  prev_data = '0;

  always #5 clock = ~clock;

  char_row_fetch #(
    .VRAM_AW    (11),
    .VRAM_BASE  (32'h7C0),
    .COLS       (64),
    .GLYPH_H    (8),
    .FIFO_DEPTH (4)
  ) u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .line_start (line_start),
    .line_num   (line_num),
    .vram_cs    (vram_cs),
    .vram_addr  (vram_addr),
    .vram_q     (vram_q),
    .crom_addr  (crom_addr),
    .crom_q     (crom_q),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .busy       (busy),
    .line_done  (line_done)
  );

  // Memory models: registered reads, one cycle latency.
  always @(posedge clock) begin
    if (vram_cs) vram_q <= vmem[vram_addr];
    crom_q <= crom[crom_addr];
  end

  // Monitor: logs handshakes/fetches and stream stability; cyc labels the cycle ending here.
  always @(posedge clock) begin
    if (pix_valid && pix_ready) got.push_back(pix_data);
    if (vram_cs) addrs.push_back(vram_addr);
    if (line_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (pix_valid && first_v < 0) first_v = cyc;
    if (32'(u_dut.fifo_count) > max_cnt) max_cnt = 32'(u_dut.fifo_count);
    if (prev_rst_n && prev_valid && !prev_pop && (!pix_valid || pix_data !== prev_data))
      stab_err = stab_err + 1;
    prev_rst_n = reset_n;
    prev_valid = pix_valid;
    prev_pop   = pix_valid && pix_ready;
    prev_data  = pix_data;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] code, input logic [2:0] g);
    logic [7:0] b;
`ifdef INVERSE_VIDEO_EN
    b = crom[{1'b0, code[6:0], g}];
    if (code[7]) b = ~b;
`else
    b = crom[{code, g}];
`endif
    return b;
  endfunction

  // Returns in cycle 0 of the new line (line_start sampled at the edge just passed).
  task automatic start_line(input logic [7:0] ln);
    @(negedge clock);
    got.delete();
    addrs.delete();
    first_v    = -1;
    max_cnt    = 0;
    stab_err   = 0;
    d0         = done_cnt;
    line_start = 1'b1;
    line_num   = ln;
    @(negedge clock);
    line_start = 1'b0;
    s0         = cyc;
  endtask

  task automatic finish_line(input int pct, input int poke);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      pix_ready  = ($urandom_range(0, 99) < pct);
      line_start = (n == poke);
      line_num   = 8'd0;
      @(negedge clock);
      n++;
    end
    line_start = 1'b0;
    pix_ready  = 1'b1;
    chk("line_done_seen", done_cnt - d0, 1);
  endtask

  task automatic check_line(input string tag, input logic [7:0] ln);
    logic [10:0] a;
    logic [2:0]  g;
    int          row;
    row = 32'(ln) / 8;
    g   = ln[2:0];
    chk($sformatf("%s_bytes", tag), got.size(), 64);
    chk($sformatf("%s_fetches", tag), addrs.size(), 64);
    chk($sformatf("%s_fifo_max_ok", tag), 32'(max_cnt <= 4), 1);
    chk($sformatf("%s_stable", tag), stab_err, 0);
    for (int i = 0; i < 64; i++) begin
      a = 11'(32'h7C0 + row * 64 + i);
      if (i < addrs.size()) chk($sformatf("%s_addr%0d", tag, i), addrs[i], a);
      if (i < got.size())   chk($sformatf("%s_data%0d", tag, i), got[i], exp_byte(vmem[a], g));
    end
  endtask

  initial begin
    logic [10:0] av;
    for (int a = 0; a < 2048; a++) begin
      av      = 11'(a);
      vmem[a] = av[7:0] ^ 8'h55;
      crom[a] = av[10:3] ^ {5'b0, av[2:0]};
    end
    for (int c = 0; c < 64; c++) vmem[11'h040 + 11'(c)] = 8'(c);
    vmem[11'h080] = 8'h81;
    crom[11'h408] = 8'h3C;
    crom[11'h008] = 8'h3C;

    reset_n    = 1'b0;
    line_start = 1'b0;
    line_num   = 8'd0;
    pix_ready  = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_vram_cs", vram_cs, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_crom_addr", crom_addr, 0);
    chk("rst_pix_data", pix_data, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Row 2, glyph row 3: bytes c^3, first valid at cycle 3, line_done at cycle 67.
    start_line(8'd19);
    chk("basic_busy", busy, 1);
    finish_line(100, -1);
    chk("basic_first_valid_cyc", first_v - s0, 3);
    chk("basic_done_cyc", done_cyc - s0, 67);
    chk("basic_busy_after", busy, 0);
    chk("basic_done_pulse", line_done, 0);
    if (got.size() == 64) begin
      chk("basic_first_byte", got[0], 8'h03);
      chk("basic_last_byte", got[63], 8'h3C);
    end
    if (addrs.size() == 64) begin
      chk("basic_first_addr", addrs[0], 11'h040);
      chk("basic_last_addr", addrs[63], 11'h07F);
    end
    check_line("basic", 8'd19);

    // Backpressure: consumer ready about 30% of cycles.
    start_line(8'd19);
    finish_line(30, -1);
    check_line("bp", 8'd19);

    // 0x7C0 + 64 wraps to 0x000.
    start_line(8'd8);
    finish_line(100, -1);
    if (addrs.size() == 64) begin
      chk("wrap_first_addr", addrs[0], 11'h000);
      chk("wrap_last_addr", addrs[63], 11'h03F);
    end
    if (got.size() == 64) chk("wrap_first_byte", got[0], 8'h55);
    check_line("wrap", 8'd8);

    // line_start during a line is ignored.
    start_line(8'd19);
    finish_line(100, 20);
    chk("ign_done_cyc", done_cyc - s0, 67);
    repeat (6) @(negedge clock);
    chk("ign_one_done", done_cnt - d0, 1);
    chk("ign_idle", busy, 0);
    check_line("ign", 8'd19);

    // Reset mid-line at column ~30.
    start_line(8'd19);
    repeat (30) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_vram_cs", vram_cs, 0);
    chk("mid_rst_pix_valid", pix_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vram_addr", vram_addr, 0);
    chk("mid_rst_crom_addr", crom_addr, 0);
    chk("mid_rst_pix_data", pix_data, 0);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (5) @(negedge clock);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    start_line(8'd19);
    finish_line(100, -1);
    check_line("post_rst", 8'd19);

    // Row 3 col 0 holds code 0x81 with glyph byte 0x3C.
    start_line(8'd24);
    @(negedge clock);
`ifdef INVERSE_VIDEO_EN
    chk("inv_crom_addr", crom_addr, 11'h008);
`else
    chk("inv_crom_addr", crom_addr, 11'h408);
`endif
    finish_line(100, -1);
    if (got.size() == 64) begin
`ifdef INVERSE_VIDEO_EN
      chk("inv_byte", got[0], 8'hC3);
`else
      chk("inv_byte", got[0], 8'h3C);
`endif
    end
    check_line("inv", 8'd24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
